biquad_coef_loader: RTL



---
 rtl/biquad_pkg.sv | 22 ++
 rtl/biquad_coef_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/biquad_pkg.sv
// Shared types and constants for the biquad coefficient loader.
package biquad_pkg;

   // Loader control states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      BACKOFF = 3'd2,
      UPDATE  = 3'd3,
      FLUSH   = 3'd4
   } bq_state_e;

   // Byte-address bit that selects filter stage B
   localparam int BQ_STAGE_BIT = 7;

   // Width of the per-stage register index
   localparam int REG_IDX_W = 5;

   // All byte lanes enabled for every coefficient write
   localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/biquad_coef_loader.sv
// Wishbone initiator that writes a stream of biquad coefficients, one
// single-beat write per word, with retry/timeout handling, and pulses the
// notch update strobe once a burst has been written cleanly.
module biquad_coef_loader
   import biquad_pkg::*;
#(
   parameter     WBCLKTYPE = "NONE",
   parameter int TIMEOUT   = 255,
   parameter int MAXRETRY  = 3
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_n_i,
   input  logic [REG_IDX_W:0]   coef_adr_i,
   input  logic [31:0]          coef_dat_i,
   input  logic                 coef_last_i,
   input  logic                 coef_valid_i,
   output logic                 coef_ready_o,
   output logic                 wbm_cyc_o,
   output logic                 wbm_stb_o,
   output logic                 wbm_we_o,
   output logic [7:0]           wbm_adr_o,
   output logic [31:0]          wbm_dat_o,
   output logic [3:0]           wbm_sel_o,
   input  logic                 wbm_ack_i,
   input  logic                 wbm_err_i,
   input  logic                 wbm_rty_i,
   input  logic [31:0]          wbm_dat_i,
   output logic                 notch_update_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [7:0]           wr_count_o
);

   localparam logic [7:0] TIMEOUT_C   = 8'(TIMEOUT);
   localparam logic [3:0] MAX_RETRY_C = 4'(MAXRETRY);

   // The clock-domain tag and read data have no function in a write-only master.
   localparam int unused_clktype_bits = $bits(WBCLKTYPE);
   logic unused_rd_data;
   assign unused_rd_data = ^wbm_dat_i;

   bq_state_e            state_reg, state_next;
   logic [REG_IDX_W:0]   adr_reg, adr_next;
   logic [31:0]          dat_reg, dat_next;
   logic                 last_reg, last_next;
   logic [3:0]           retry_reg, retry_next;
   logic [7:0]           tmo_reg, tmo_next;
   logic                 err_reg, err_next;
   logic [7:0]           cnt_reg, cnt_next;
   // Set once a burst has ended, so the next accepted word restarts the count
   logic                 fin_reg, fin_next;
   logic                 done_reg, done_next;
   logic                 fail;
   logic [7:0]           adr_bus;

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state_reg <= IDLE;
         adr_reg   <= '0;
         dat_reg   <= '0;
         last_reg  <= 1'b0;
         retry_reg <= '0;
         tmo_reg   <= '0;
         err_reg   <= 1'b0;
         cnt_reg   <= '0;
         fin_reg   <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         adr_reg   <= adr_next;
         dat_reg   <= dat_next;
         last_reg  <= last_next;
         retry_reg <= retry_next;
         tmo_reg   <= tmo_next;
         err_reg   <= err_next;
         cnt_reg   <= cnt_next;
         fin_reg   <= fin_next;
         done_reg  <= done_next;
      end
   end

   // Next-state, counter updates and state-decoded outputs
   always_comb begin
      state_next     = state_reg;
      adr_next       = adr_reg;
      dat_next       = dat_reg;
      last_next      = last_reg;
      retry_next     = retry_reg;
      tmo_next       = tmo_reg;
      err_next       = err_reg;
      cnt_next       = cnt_reg;
      fin_next       = fin_reg;
      done_next      = 1'b0;
      fail           = 1'b0;
      coef_ready_o   = 1'b0;
      wbm_cyc_o      = 1'b0;
      notch_update_o = 1'b0;

      case (state_reg)
         IDLE: begin
            coef_ready_o = 1'b1;
            if (coef_valid_i) begin
               adr_next   = coef_adr_i;
               dat_next   = coef_dat_i;
               last_next  = coef_last_i;
               retry_next = '0;
               tmo_next   = '0;
               err_next   = 1'b0;
               if (fin_reg) begin
                  cnt_next = '0;
                  fin_next = 1'b0;
               end
               state_next = REQ;
            end
         end

         REQ: begin
            wbm_cyc_o = 1'b1;
            // err wins over rty, rty over ack; timeout only with no response
            if (wbm_err_i) begin
               fail = 1'b1;
            end else if (wbm_rty_i) begin
               if (retry_reg < MAX_RETRY_C) begin
                  retry_next = retry_reg + 4'd1;
                  state_next = BACKOFF;
               end else begin
                  fail = 1'b1;
               end
            end else if (wbm_ack_i) begin
               if (cnt_reg != 8'hFF) begin
                  cnt_next = cnt_reg + 8'd1;
               end
               state_next = last_reg ? UPDATE : IDLE;
            end else if (tmo_reg == TIMEOUT_C - 8'd1) begin
               fail = 1'b1;
            end else begin
               tmo_next = tmo_reg + 8'd1;
            end

            if (fail) begin
               err_next = 1'b1;
               if (last_reg) begin
                  done_next  = 1'b1;
                  fin_next   = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = FLUSH;
               end
            end
         end

         BACKOFF: begin
            tmo_next   = '0;
            state_next = REQ;
         end

         UPDATE: begin
            notch_update_o = 1'b1;
            fin_next       = 1'b1;
            state_next     = IDLE;
         end

         FLUSH: begin
            coef_ready_o = 1'b1;
            if (coef_valid_i && coef_last_i) begin
               done_next  = 1'b1;
               fin_next   = 1'b1;
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Map {stage, register index} onto the 8-bit byte address
   always_comb begin
      adr_bus                 = '0;
      adr_bus[BQ_STAGE_BIT]   = adr_reg[REG_IDX_W];
      adr_bus[2 +: REG_IDX_W] = adr_reg[REG_IDX_W-1:0];
   end

   assign wbm_stb_o  = wbm_cyc_o;
   assign wbm_we_o   = wbm_cyc_o;
   assign wbm_adr_o  = adr_bus;
   assign wbm_dat_o  = dat_reg;
   assign wbm_sel_o  = SEL_ALL;
   assign done_o     = done_reg | (state_reg == UPDATE);
   assign err_o      = err_reg;
   assign wr_count_o = cnt_reg;

endmodule
